// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter sharing one 4-digit 7-segment display between N_REQ producers.
// Grants one producer at a time for a minimum dwell and forwards its word, registered.
module seg_disp_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   data_in,
  output logic [N_REQ-1:0]      grant,
  output logic [2:0]            owner,
  output logic                  busy,
  output logic [15:0]           data_out
);

  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  ptr;

  logic              win_found_c;
  logic [IDX_W-1:0]  win_idx_c;
  logic [15:0]       win_word_c;
  logic [15:0]       own_word_c;
  logic              own_req_c;

  // Round-robin search starting after the last owner; the last owner itself is checked last.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = ptr;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!win_found_c && req[i] &&
            (IDX_W'((32'(ptr) + k) % N_REQ) == IDX_W'(i))) begin
          win_found_c = 1'b1;
          win_idx_c   = IDX_W'(i);
        end
      end
    end
  end

  // Word and request-level selection for the winner and the current owner.
  always_comb begin
    win_word_c = 16'h0000;
    own_word_c = 16'h0000;
    own_req_c  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx_c == IDX_W'(i)) win_word_c = data_in[16*i +: 16];
      if (owner == IDX_W'(i)) begin
        own_word_c = data_in[16*i +: 16];
        own_req_c  = req[i];
      end
    end
  end

  // Grant FSM with registered outputs; IDLE keeps owner/data_out so no blank frame appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      grant    <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      data_out <= 16'h0000;
      cnt      <= '0;
      ptr      <= PTR_RST;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found_c) begin
            state    <= S_HOLD;
            grant    <= N_REQ'(1) << win_idx_c;
            owner    <= win_idx_c;
            ptr      <= win_idx_c;
            busy     <= 1'b1;
            cnt      <= '0;
            data_out <= win_word_c;
          end
        end
        S_HOLD: begin
          data_out <= own_word_c;
          if (!own_req_c) begin
            // Owner released: the winner cannot be the owner since its request is low.
            if (win_found_c) begin
              grant <= N_REQ'(1) << win_idx_c;
              owner <= win_idx_c;
              ptr   <= win_idx_c;
              cnt   <= '0;
            end else begin
              state <= S_IDLE;
              grant <= '0;
              busy  <= 1'b0;
              cnt   <= '0;
            end
          end else if (cnt == CNT_LAST) begin
            if (win_found_c && (win_idx_c != ptr)) begin
              grant <= N_REQ'(1) << win_idx_c;
              owner <= win_idx_c;
              ptr   <= win_idx_c;
            end
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter with a short dwell; expected values computed by hand.
module tb_seg_disp_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned DWELL = 8;
  localparam int unsigned CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] data_in;
  logic [N_REQ-1:0]    grant;
  logic [2:0]          owner;
  logic                busy;
  logic [15:0]         data_out;

  int total = 0;
  int bad   = 0;

  seg_disp_arbiter #(.N_REQ(N_REQ), .DWELL_CYCLES(DWELL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .grant(grant), .owner(owner), .busy(busy), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [15:0] w);
    data_in[16*i +: 16] = w;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [3:0]  exp_g [4];
  logic [15:0] exp_w [4];

  initial begin
    rst = 1'b1;
    req = '0;
    data_in = '0;
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    rst = 1'b0;
    tick();

    // Single requester with repeated dwell extensions.
    set_word(2, 16'h1234);
    req = 4'b0100;
    tick();
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_owner", 32'(owner), 32'h2);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_data", 32'(data_out), 32'h1234);
    repeat (20) tick();
    chk("single_ext_grant", 32'(grant), 32'h4);
    chk("single_ext_data", 32'(data_out), 32'h1234);

    // Rotation among requesters 0, 1, 3.
    do_reset();
    set_word(0, 16'h1111); set_word(1, 16'h2222);
    set_word(2, 16'h3333); set_word(3, 16'h4444);
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
    exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h4444; exp_w[3] = 16'h1111;
    req = 4'b1011;
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        chk("rot_grant", 32'(grant), 32'(exp_g[g]));
        if (c == 0)
          chk("rot_data_first", 32'(data_out), 32'((g == 0) ? exp_w[0] : exp_w[g-1]));
        if (c == 1)
          chk("rot_data_next", 32'(data_out), 32'(exp_w[g]));
      end
    end

    // Early release by owner 0 at cnt=3 while requester 3 waits.
    do_reset();
    req = 4'b1001;
    tick();
    chk("early_first", 32'(grant), 32'h1);
    repeat (3) tick();
    req = 4'b1000;
    tick();
    chk("early_move", 32'(grant), 32'h8);
    chk("early_owner", 32'(owner), 32'h3);
    req = 4'b1001;
    for (int c = 1; c < 8; c++) begin
      tick();
      chk("early_dwell", 32'(grant), 32'h8);
    end
    tick();
    chk("early_rotate", 32'(grant), 32'h1);

    // Sole owner releases: display holds the last word.
    do_reset();
    set_word(1, 16'h0525);
    req = 4'b0010;
    tick();
    chk("idle_grant", 32'(grant), 32'h2);
    tick();
    req = '0;
    tick();
    set_word(1, 16'hFFFF);
    chk("idle_grant0", 32'(grant), 32'h0);
    chk("idle_busy0", 32'(busy), 32'h0);
    repeat (100) tick();
    chk("idle_data", 32'(data_out), 32'h0525);
    chk("idle_owner", 32'(owner), 32'h1);
    chk("idle_busy", 32'(busy), 32'h0);

    // Live word update during a grant.
    do_reset();
    set_word(2, 16'h0100);
    req = 4'b0100;
    tick();
    tick();
    chk("live_before", 32'(data_out), 32'h0100);
    set_word(2, 16'h0200);
    #1;
    chk("live_hold", 32'(data_out), 32'h0100);
    tick();
    chk("live_after", 32'(data_out), 32'h0200);
    chk("live_grant", 32'(grant), 32'h4);

    // Asynchronous reset mid-HOLD, then arbitration restarts at requester 0.
    do_reset();
    req = 4'b0100;
    tick();
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_data", 32'(data_out), 32'h0);
    req = 4'b1111;
    tick();
    rst = 1'b0;
    tick();
    chk("arst_first", 32'(grant), 32'h1);
    chk("arst_owner", 32'(owner), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
